// File: rtl/ioctl_upload_reader.sv
// Purpose: serves data_io upload reads of a core RAM window, pausing the core for the whole session.
// Latency: in-window byte valid on ioctl_din RAM_LAT+2 clocks after the ioctl_rd rise; out-of-window returns FF after 1 clock.
// Backpressure: ioctl_ready is low while a fetch is in flight; ioctl_rd rises then are dropped and flagged in overrun.
module ioctl_upload_reader #(
  parameter int          ADDR_W  = 11,
  parameter logic [24:0] BASE    = 25'h0,
  parameter int          SIZE    = 2048,
  parameter int          RAM_LAT = 2,
  parameter logic [7:0]  INDEX   = 8'h03
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_ready,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic [7:0]        checksum,
  output logic              overrun,
  output logic              upload_done
);

  typedef enum logic [2:0] {
    IDLE,
    PAUSE_WAIT,
    READY,
    FETCH,
    RELEASE
  } state_t;

  // Window bounds carried in 26 bits so BASE+SIZE never wraps the 25-bit address space.
  localparam logic [25:0] WIN_LO = {1'b0, BASE};
  localparam logic [25:0] WIN_SZ = 26'(SIZE);
  localparam logic [2:0]  LAT_LD = 3'(RAM_LAT);

  state_t      state, state_nxt;
  logic        rst_meta_n, rst_sync_n;
  logic        upload_q, rd_q;
  logic        upload_rise, rd_rise;
  logic [25:0] addr_off;
  logic        in_window;
  logic [2:0]  wait_cnt;

  logic        start_session;
  logic        go_ready;
  logic        go_release;
  logic        issue_fetch;
  logic        oow_read;
  logic        capture;
  logic        overrun_set;

  // Reset synchronizer: assertion reaches every flop at once, release lines up with the clock.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  assign upload_rise = ioctl_upload & ~upload_q;
  assign rd_rise     = ioctl_rd & ~rd_q;

  // An address below BASE underflows into bit 25, so one unsigned compare covers both bounds.
  assign addr_off  = {1'b0, ioctl_addr} - WIN_LO;
  assign in_window = (addr_off < WIN_SZ);

  // Previous-cycle copies of the host strobes for edge detection.
  always_ff @(posedge clk_sys or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      upload_q <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      rd_q     <= ioctl_rd;
    end
  end

  // Session state register.
  always_ff @(posedge clk_sys or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle datapath controls; upload going low always beats a read request.
  always_comb begin
    state_nxt     = state;
    start_session = 1'b0;
    go_ready      = 1'b0;
    go_release    = 1'b0;
    issue_fetch   = 1'b0;
    oow_read      = 1'b0;
    capture       = 1'b0;
    overrun_set   = 1'b0;
    case (state)
      IDLE: begin
        if (upload_rise && (ioctl_index == INDEX)) begin
          start_session = 1'b1;
          state_nxt     = PAUSE_WAIT;
        end
      end
      PAUSE_WAIT: begin
        if (!ioctl_upload) begin
          go_release = 1'b1;
          state_nxt  = RELEASE;
        end else if (pause_ack) begin
          go_ready  = 1'b1;
          state_nxt = READY;
        end
      end
      READY: begin
        if (!ioctl_upload) begin
          go_release = 1'b1;
          state_nxt  = RELEASE;
        end else if (rd_rise) begin
          if (in_window) begin
            issue_fetch = 1'b1;
            state_nxt   = FETCH;
          end else begin
            oow_read = 1'b1;
          end
        end
      end
      FETCH: begin
        if (!ioctl_upload) begin
          go_release = 1'b1;
          state_nxt  = RELEASE;
        end else begin
          overrun_set = rd_rise;
          if (wait_cnt == 3'd0) begin
            capture   = 1'b1;
            state_nxt = READY;
          end
        end
      end
      RELEASE: begin
        if (!pause_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs: host handshake, RAM strobe, returned byte, checksum and status flags.
  always_ff @(posedge clk_sys or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      pause_req   <= 1'b0;
      ioctl_ready <= 1'b0;
      ioctl_din   <= 8'h00;
      ram_addr    <= '0;
      ram_rd      <= 1'b0;
      wait_cnt    <= 3'd0;
      checksum    <= 8'h00;
      overrun     <= 1'b0;
      upload_done <= 1'b0;
    end else begin
      ram_rd      <= issue_fetch;
      upload_done <= go_release;

      if (start_session) begin
        pause_req <= 1'b1;
        checksum  <= 8'h00;
        overrun   <= 1'b0;
      end
      if (go_release) begin
        pause_req <= 1'b0;
      end

      if (go_ready || capture) begin
        ioctl_ready <= 1'b1;
      end else if (issue_fetch || go_release) begin
        ioctl_ready <= 1'b0;
      end

      if (issue_fetch) begin
        ram_addr <= addr_off[ADDR_W-1:0];
        wait_cnt <= LAT_LD;
      end else if ((state == FETCH) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (oow_read) begin
        ioctl_din <= 8'hFF;
      end else if (capture) begin
        ioctl_din <= ram_q;
        checksum  <= checksum + ram_q;
      end

      if (overrun_set) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Purpose: directed bench for ioctl_upload_reader with a two-stage RAM model.
// Latency: every check is placed at the exact cycle the expected value must appear.
// Backpressure: exercises dropped reads (overrun) and aborts while a fetch is in flight.
module tb_ioctl_upload_reader;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_ready;
  logic        pause_req;
  logic        pause_ack;
  logic [10:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic [7:0]  checksum;
  logic        overrun;
  logic        upload_done;

  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int done_pulses = 0;
  int snap_rd;
  int snap_done;

  logic [7:0] mem [0:2047];
  logic [7:0] ram_p1;

  ioctl_upload_reader dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_ready  (ioctl_ready),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_q        (ram_q),
    .checksum     (checksum),
    .overrun      (overrun),
    .upload_done  (upload_done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // RAM with two clocks from strobe to data; unstrobed cycles return EE so mistimed captures show up.
  always @(posedge clk_sys) begin
    ram_p1 <= ram_rd ? mem[ram_addr] : 8'hEE;
    ram_q  <= ram_p1;
  end

  // Pulse counters sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (ram_rd === 1'b1) rd_pulses++;
    if (upload_done === 1'b1) done_pulses++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // In-window read: strobe one cycle after the rise, byte exactly four cycles after it.
  task automatic do_read(input logic [24:0] addr, input logic [7:0] exp, input logic [7:0] exp_cs);
    logic [10:0] a;
    a = addr[10:0];
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick();
    check("ram_rd_strobe", ram_rd, 1'b1);
    check("ram_addr", ram_addr, a);
    ioctl_rd = 1'b0;
    tick();
    check("ram_rd_single", ram_rd, 1'b0);
    tick();
    check("ready_not_early", ioctl_ready, 1'b0);
    tick();
    check("ready_after_fetch", ioctl_ready, 1'b1);
    check("din", ioctl_din, exp);
    check("checksum", checksum, exp_cs);
  endtask

  // Out-of-window read: FF one cycle later, no RAM access, checksum untouched.
  task automatic oow_read(input logic [24:0] addr, input logic [7:0] exp_cs);
    snap_rd    = rd_pulses;
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick();
    check("oow_din", ioctl_din, 8'hFF);
    check("oow_ready", ioctl_ready, 1'b1);
    check("oow_checksum", checksum, exp_cs);
    ioctl_rd = 1'b0;
    tick();
    check("oow_no_ram_rd", rd_pulses - snap_rd, 0);
  endtask

  task automatic start_session();
    ioctl_index  = 8'h03;
    ioctl_upload = 1'b1;
    tick();
    check("pause_req_on_start", pause_req, 1'b1);
    pause_ack = 1'b1;
    tick();
    check("ready_on_ack", ioctl_ready, 1'b1);
  endtask

  task automatic end_session();
    snap_done    = done_pulses;
    ioctl_upload = 1'b0;
    tick();
    check("release_pause_req", pause_req, 1'b0);
    check("release_done", upload_done, 1'b1);
    check("release_ready", ioctl_ready, 1'b0);
    tick();
    pause_ack = 1'b0;
    tick();
    tick();
    check("done_pulse_count", done_pulses - snap_done, 1);
  endtask

  initial begin
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'h00;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 25'h0;
    pause_ack    = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[5] = 8'hFF; mem[6] = 8'h02; mem[7] = 8'h5A; mem[8] = 8'h77;

    // Reset state
    tick(); tick(); tick();
    check("rst_pause_req", pause_req, 1'b0);
    check("rst_ready", ioctl_ready, 1'b0);
    check("rst_din", ioctl_din, 8'h00);
    check("rst_checksum", checksum, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ram_rd", ram_rd, 1'b0);
    check("rst_done", upload_done, 1'b0);
    reset_n = 1'b1;
    tick(); tick(); tick();

    // Wrong index: block stays idle even with read requests
    snap_rd      = rd_pulses;
    ioctl_index  = 8'h01;
    ioctl_upload = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ioctl_rd = 1'b1; tick();
      ioctl_rd = 1'b0; tick();
    end
    check("wrong_idx_pause_req", pause_req, 1'b0);
    check("wrong_idx_ready", ioctl_ready, 1'b0);
    check("wrong_idx_ram_rd", rd_pulses - snap_rd, 0);
    ioctl_upload = 1'b0;
    tick(); tick();

    // Basic read: ack arrives five cycles after the request
    ioctl_index  = 8'h03;
    ioctl_upload = 1'b1;
    tick();
    check("basic_pause_req", pause_req, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("ready_before_ack", ioctl_ready, 1'b0);
    pause_ack = 1'b1;
    tick();
    check("basic_ready", ioctl_ready, 1'b1);
    do_read(25'd0, 8'h11, 8'h11);
    do_read(25'd1, 8'h22, 8'h33);
    do_read(25'd2, 8'h33, 8'h66);
    do_read(25'd3, 8'h44, 8'hAA);
    end_session();
    check("retain_checksum", checksum, 8'hAA);
    check("retain_din", ioctl_din, 8'h44);

    // Out of window and checksum wrap in one session
    start_session();
    check("new_session_checksum", checksum, 8'h00);
    oow_read(25'd2048, 8'h00);
    do_read(25'd5, 8'hFF, 8'hFF);
    do_read(25'd6, 8'h02, 8'h01);
    oow_read(25'h1FFFFFF, 8'h01);

    // Overrun: a second rise while the fetch is in flight is dropped
    snap_rd    = rd_pulses;
    ioctl_addr = 25'd7;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    ioctl_rd = 1'b1;
    tick();
    check("overrun_set", overrun, 1'b1);
    check("overrun_ready_low", ioctl_ready, 1'b0);
    tick();
    check("overrun_din", ioctl_din, 8'h5A);
    check("overrun_checksum", checksum, 8'h5B);
    ioctl_rd = 1'b0;
    tick(); tick();
    check("overrun_sticky", overrun, 1'b1);
    check("overrun_one_fetch", rd_pulses - snap_rd, 1);

    // Abort mid-fetch: byte discarded, core released next cycle
    snap_done  = done_pulses;
    ioctl_addr = 25'd8;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    check("abort_pause_req", pause_req, 1'b0);
    check("abort_done", upload_done, 1'b1);
    check("abort_ready", ioctl_ready, 1'b0);
    tick();
    check("abort_done_single", upload_done, 1'b0);
    tick(); tick(); tick();
    check("abort_din_kept", ioctl_din, 8'h5A);
    check("abort_checksum_kept", checksum, 8'h5B);
    check("abort_done_count", done_pulses - snap_done, 1);
    pause_ack = 1'b0;
    tick(); tick();
    check("overrun_after_session", overrun, 1'b1);

    // Reset mid-session drops pause_req with no clock edge
    ioctl_index  = 8'h03;
    ioctl_upload = 1'b1;
    tick();
    check("midrst_pause_before", pause_req, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_pause_async", pause_req, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    check("midrst_checksum", checksum, 8'h00);
    ioctl_upload = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_idle", pause_req, 1'b0);
    start_session();
    check("post_rst_checksum", checksum, 8'h00);
    check("post_rst_overrun", overrun, 1'b0);
    do_read(25'd1, 8'h22, 8'h22);
    end_session();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
